// File: rtl/eda_strobe_scan_ram_if.sv
// eda_strobe_scan_ram_if: bundle of mark, query, scan and result signals
// between the region controller side (master) and the visited-bit map (slave).
// The neighbour-mark signals exist only when EDA_NEIGHBOR_MARK_EN is defined.
interface eda_strobe_scan_ram_if #(
  parameter int P          = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 7
);
  logic                             clear;
  logic [P-1:0]                     mark_valid;
  logic [P-1:0][ADDR_WIDTH-1:0]     mark_addr;
  logic [ADDR_WIDTH-1:0]            query_addr;
  logic                             query_bit;
  logic                             scan_req;
  logic                             scan_busy;
  logic                             next_valid;
  logic                             next_ready;
  logic [ADDR_WIDTH-1:0]            next_addr;
  logic                             iterated_all;
  logic [CNT_WIDTH-1:0]             mark_count;
  logic                             all_marked;
`ifdef EDA_NEIGHBOR_MARK_EN
  logic                             nbr_mark_valid;
  logic [ADDR_WIDTH-1:0]            nbr_center_addr;
`endif

  modport master (
    output clear, mark_valid, mark_addr, query_addr, scan_req, next_ready,
`ifdef EDA_NEIGHBOR_MARK_EN
    output nbr_mark_valid, nbr_center_addr,
`endif
    input  query_bit, scan_busy, next_valid, next_addr, iterated_all,
    input  mark_count, all_marked
  );

  modport slave (
    input  clear, mark_valid, mark_addr, query_addr, scan_req, next_ready,
`ifdef EDA_NEIGHBOR_MARK_EN
    input  nbr_mark_valid, nbr_center_addr,
`endif
    output query_bit, scan_busy, next_valid, next_addr, iterated_all,
    output mark_count, all_marked
  );
endinterface

// File: rtl/eda_strobe_scan_ram.sv
// eda_strobe_scan_ram: M x N visited-bit map with P mark ports, a running
// count of marked pixels and a raster-order scanner that hands out the next
// unvisited pixel at or after the cursor. Defining EDA_NEIGHBOR_MARK_EN adds
// a 3x3 neighbourhood mark port clipped at the image borders.
module eda_strobe_scan_ram #(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int I_WIDTH    = 3,
  parameter int J_WIDTH    = 3,
  parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH,
  parameter int P          = 2,
  parameter int CNT_WIDTH  = $clog2(M*N+1)
) (
  input logic                 clk,
  input logic                 reset_n,
  eda_strobe_scan_ram_if.slave bus
);

  localparam int CELLS = M * N;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  state_t                state_q, state_d;
  logic [CELLS-1:0]      map_q;
  logic [CELLS-1:0]      set_vec;
  logic [CELLS-1:0]      new_bits;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  new_count;
  logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [I_WIDTH-1:0]    row_ptr_q, row_ptr_d;
  logic [N-1:0]          row_bits;
  logic [N-1:0]          col_mask;
  logic [N-1:0]          candidate;
  logic                  hit;
  logic [J_WIDTH-1:0]    hit_col;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a[ADDR_WIDTH-1:J_WIDTH]) < M) && (int'(a[J_WIDTH-1:0]) < N);
  endfunction

  function automatic int cell_index(input logic [ADDR_WIDTH-1:0] a);
    return int'(a[ADDR_WIDTH-1:J_WIDTH]) * N + int'(a[J_WIDTH-1:0]);
  endfunction

  // Collect every bit being marked this cycle from all ports into one vector,
  // so duplicates across ports collapse naturally.
  always_comb begin
    set_vec = '0;
    for (int p = 0; p < P; p++) begin
      if (bus.mark_valid[p] && in_range(bus.mark_addr[p]))
        set_vec[cell_index(bus.mark_addr[p])] = 1'b1;
    end
`ifdef EDA_NEIGHBOR_MARK_EN
    if (bus.nbr_mark_valid && in_range(bus.nbr_center_addr)) begin
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if ((int'(bus.nbr_center_addr[ADDR_WIDTH-1:J_WIDTH]) + dr >= 0) &&
              (int'(bus.nbr_center_addr[ADDR_WIDTH-1:J_WIDTH]) + dr < M) &&
              (int'(bus.nbr_center_addr[J_WIDTH-1:0]) + dc >= 0) &&
              (int'(bus.nbr_center_addr[J_WIDTH-1:0]) + dc < N))
            set_vec[(int'(bus.nbr_center_addr[ADDR_WIDTH-1:J_WIDTH]) + dr) * N +
                    int'(bus.nbr_center_addr[J_WIDTH-1:0]) + dc] = 1'b1;
        end
      end
    end
`endif
  end

  // Count only bits that flip from 0 to 1 this cycle.
  always_comb begin
    new_bits  = set_vec & ~map_q;
    new_count = '0;
    for (int i = 0; i < CELLS; i++)
      new_count = new_count + CNT_WIDTH'(new_bits[i]);
  end

  // Visited map and marked-pixel counter; clear wins over marks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      map_q   <= '0;
      count_q <= '0;
    end else if (bus.clear) begin
      map_q   <= '0;
      count_q <= '0;
    end else begin
      map_q   <= map_q | set_vec;
      count_q <= count_q + new_count;
    end
  end

  // Candidate columns of the row under scan: unvisited, including this
  // cycle's marks, and not before the cursor column on the cursor row.
  always_comb begin
    row_bits = map_q[int'(row_ptr_q)*N +: N] | set_vec[int'(row_ptr_q)*N +: N];
    col_mask = '0;
    for (int c = 0; c < N; c++)
      col_mask[c] = (row_ptr_q != cursor_q[ADDR_WIDTH-1:J_WIDTH]) ||
                    (c >= int'(cursor_q[J_WIDTH-1:0]));
    candidate = ~row_bits & col_mask;
    hit     = 1'b0;
    hit_col = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (candidate[c]) begin
        hit     = 1'b1;
        hit_col = J_WIDTH'(c);
      end
    end
  end

  // Scan FSM next-state logic, one row examined per SCAN cycle.
  always_comb begin
    state_d     = state_q;
    row_ptr_d   = row_ptr_q;
    cursor_d    = cursor_q;
    next_addr_d = next_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.scan_req) begin
          state_d   = SCAN;
          row_ptr_d = cursor_q[ADDR_WIDTH-1:J_WIDTH];
        end
      end
      SCAN: begin
        if (hit) begin
          next_addr_d = {row_ptr_q, hit_col};
          state_d     = HOLD;
        end else if (int'(row_ptr_q) < M - 1) begin
          row_ptr_d = row_ptr_q + I_WIDTH'(1);
        end else begin
          state_d = DONE;
        end
      end
      HOLD: begin
        if (bus.next_ready) begin
          cursor_d = next_addr_q;
          state_d  = IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan FSM registers; clear aborts any scan and rewinds the cursor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_ptr_q   <= '0;
      cursor_q    <= '0;
      next_addr_q <= '0;
    end else if (bus.clear) begin
      state_q   <= IDLE;
      row_ptr_q <= '0;
      cursor_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_ptr_q   <= row_ptr_d;
      cursor_q    <= cursor_d;
      next_addr_q <= next_addr_d;
    end
  end

  assign bus.query_bit    = in_range(bus.query_addr) ? map_q[cell_index(bus.query_addr)] : 1'b0;
  assign bus.scan_busy    = (state_q == SCAN);
  assign bus.next_valid   = (state_q == HOLD);
  assign bus.next_addr    = next_addr_q;
  assign bus.iterated_all = (state_q == DONE);
  assign bus.mark_count   = count_q;
  assign bus.all_marked   = (count_q == CNT_WIDTH'(CELLS));

endmodule
